xge_pkt_rx_sink: RTL
====================

# xge_pkt_rx_sink

Frame reader for the xge_mac receive packet interface, operating in the 156.25 MHz core domain. Drives `pkt_rx_ren` whenever the MAC reports a frame available, consumes words until end-of-packet, and reports each frame's byte length and error status. Checks SOP/EOP framing and keeps saturating-free wrap-around statistics counters. Sits beside the MAC as the consumer end of the `pkt_rx_*` interface; the MAC is the writer.

## Interface
- `CNT_W`, 32: width of the statistics counters.
- `LEN_W`, 16: width of the per-frame byte length; the length saturates at all-ones.
- `clk_156m25` input 1: core clock; all logic is on its rising edge.
- `reset_156m25_n` input 1: asynchronous, active-low reset.
- `pkt_rx_avail` input 1: the MAC holds at least one complete frame.
- `pkt_rx_data` input 64: receive data word.
- `pkt_rx_val` input 1: `pkt_rx_data` and the flags are valid this cycle.
- `pkt_rx_sop` input 1: first word of a frame.
- `pkt_rx_eop` input 1: last word of a frame.
- `pkt_rx_mod` input 3: valid bytes in the EOP word; 0 means 8.
- `pkt_rx_err` input 1: frame error flag, sampled on the EOP word.
- `pkt_rx_ren` output 1: read enable to the MAC; registered.
- `stall` input 1: the consumer requests a pause; `pkt_rx_ren` drops on the next edge.
- `clear_stats` input 1: synchronous clear of all counters.
- `frame_done` output 1: one-cycle pulse when a frame completes.
- `frame_len` output LEN_W: byte length of the completed frame; held until the next `frame_done`.
- `frame_bad` output 1: the completed frame had `pkt_rx_err` set; held with `frame_len`.
- `busy` output 1: the state machine is not IDLE.
- `frames_ok`, `frames_err`, `framing_err` output CNT_W each: frame counters.
- `bytes_total` output CNT_W: byte counter.

## Operation
**States**
- IDLE: `pkt_rx_ren`=0. Go to READ when `pkt_rx_avail && !stall`; `pkt_rx_ren` rises on that edge.
- READ: `pkt_rx_ren` = `!stall`, registered. Stay in READ until a valid EOP word is consumed.
- DONE: one cycle, with `pkt_rx_ren`=0. Publish the results, then return to IDLE.

**Word handling** (only in cycles with `pkt_rx_val`=1)
- SOP word: `len` = word_bytes.
- Other words: `len` += word_bytes.
- word_bytes = 8, except on an EOP word, where it is (`pkt_rx_mod`==0 ? 8 : `pkt_rx_mod`).
- A single word with SOP and EOP both set is a complete frame.
- Length arithmetic is LEN_W+1 bits wide; the result clamps to 2^LEN_W−1.

**Frame completion** (EOP word)
- Latch `frame_len` and `frame_bad` = `pkt_rx_err`.
- Increment `frames_ok` or `frames_err`.
- Add `len` to `bytes_total`, which wraps modulo 2^CNT_W.
- Pulse `frame_done` during the DONE cycle.

**Framing errors** (each increments `framing_err`)
- SOP while a frame is open (an SOP already seen, no EOP yet): the open frame is discarded uncounted and the new frame starts.
- A valid non-SOP word with no frame open: the word is dropped.
- EOP with no frame open: the word is dropped. There is no `frame_done`.

**Other rules**
- `pkt_rx_val` in IDLE or DONE is still processed; the MAC has one cycle of read latency.
- All counters wrap modulo 2^CNT_W.
- `clear_stats` zeroes all counters. If a frame completes in the same cycle, clear wins and that frame is not counted; `frame_len` and `frame_bad` still update.

## Timing
- Reset values: `pkt_rx_ren`=0, `frame_done`=0, `frame_len`=0, `frame_bad`=0, `busy`=0, all counters 0. State is IDLE and no frame is open.
- MAC read latency is one cycle: `pkt_rx_val` follows `pkt_rx_ren` by one edge.
- EOP sampled at edge N:
  - `pkt_rx_ren` is 0 from N+1.
  - `frame_done`, `frame_len`, `frame_bad` and the counters are visible from N+1.
  - The earliest re-assertion of `pkt_rx_ren` is N+2.
- `stall` rising at edge N sets `pkt_rx_ren`=0 from N+1. At most one more valid word arrives, at N+1, and it is accepted.
- Reset mid-frame: all state clears asynchronously and the partial frame is lost. After reset the block resynchronises on the next SOP; words before that SOP count as framing errors.

## Structure
- `xge_pkt_rx_sink_pkg` holds:
  - the state enum `{IDLE, READ, DONE}`;
  - the constant `XGE_WORD_BYTES`=8;
  - a function `mod_to_bytes(mod)` returning 1..8.
- Sub-module `xge_stat_counter`: CNT_W-bit wrapping counter with a clear and an add-value input. Instantiate it four times, one per statistics counter.

## Test plan
- Single 64-byte frame, no error (8 words, `pkt_rx_mod`=0) -> `frame_len`=64, `frames_ok`=1, `bytes_total`=64, `pkt_rx_ren` low the edge after EOP.
- 61-byte frame with `pkt_rx_err`=1 (8 words, `pkt_rx_mod`=5) -> `frame_len`=61, `frame_bad`=1, `frames_err`=1, `frames_ok` unchanged.
- `stall` held for 3 cycles mid-frame -> `pkt_rx_ren` low for 3 cycles, no words lost, `frame_len` correct, one extra word accepted after `stall` rises.
- Second SOP 3 words into an open frame, then a 2-word frame -> `framing_err`=1, then `frame_len`=16 with `frames_ok`=1.
- `clear_stats` asserted in the frame-completion cycle -> all counters read 0 and `frame_len` is updated. `bytes_total` preloaded to 2^32−10 plus a 64-byte frame -> wraps to 54.
- `reset_156m25_n` pulsed mid-frame -> all outputs return to reset values immediately. The next clean frame is counted correctly, and stray non-SOP words before it increment `framing_err`.

Source files
------------

// File: rtl/xge_pkt_rx_sink_pkg.sv
// Shared types and helpers for the xge_mac receive-side frame reader.
// Holds the reader state encoding and the EOP byte-count decode.
package xge_pkt_rx_sink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } rx_state_e;

    localparam int unsigned XGE_WORD_BYTES = 8;

    // The MAC encodes a full 8-byte EOP word as mod==0.
    function automatic logic [3:0] mod_to_bytes(input logic [2:0] mod);
        return (mod == 3'd0) ? 4'(XGE_WORD_BYTES) : {1'b0, mod};
    endfunction

endpackage

// File: rtl/xge_stat_counter.sv
// Wrapping statistics counter: adds a value every cycle, synchronous clear wins.
module xge_stat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic [W-1:0] add_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = clr_i ? '0 : count_q + add_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/xge_pkt_rx_sink.sv
// Consumer end of the xge_mac pkt_rx interface: reads frames, measures their
// byte length, flags errored frames and counts frames, bytes and framing faults.
module xge_pkt_rx_sink
    import xge_pkt_rx_sink_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk_156m25,
    input  logic             reset_156m25_n,
    input  logic             pkt_rx_avail,
    input  logic [63:0]      pkt_rx_data,
    input  logic             pkt_rx_val,
    input  logic             pkt_rx_sop,
    input  logic             pkt_rx_eop,
    input  logic [2:0]       pkt_rx_mod,
    input  logic             pkt_rx_err,
    output logic             pkt_rx_ren,
    input  logic             stall,
    input  logic             clear_stats,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_bad,
    output logic             busy,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_err,
    output logic [CNT_W-1:0] framing_err,
    output logic [CNT_W-1:0] bytes_total
);

    // Handshake: pkt_rx_ren sampled high by the MAC at edge N obliges it to
    // present one word with pkt_rx_val=1 for edge N+1; every word with
    // pkt_rx_val=1 is accepted unconditionally, whatever the reader state.

    rx_state_e        state_q;
    logic             ren_q;
    logic             done_q;
    logic             open_q, open_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] frame_len_q;
    logic             frame_bad_q;

    logic [3:0]       word_bytes;
    logic [LEN_W:0]   sum;
    logic [LEN_W-1:0] done_len;
    logic             complete;
    logic             fr_err;
    logic             unused_data;

    assign unused_data = ^pkt_rx_data;

    always_comb begin
        word_bytes = pkt_rx_eop ? mod_to_bytes(pkt_rx_mod) : 4'(XGE_WORD_BYTES);
        sum        = {1'b0, len_q} + (LEN_W + 1)'(word_bytes);
        open_d     = open_q;
        len_d      = len_q;
        done_len   = len_q;
        complete   = 1'b0;
        fr_err     = 1'b0;
        if (pkt_rx_val) begin
            if (pkt_rx_sop) begin
                // A new SOP always restarts; an open frame is abandoned.
                fr_err   = open_q;
                done_len = LEN_W'(word_bytes);
                len_d    = done_len;
                complete = pkt_rx_eop;
                open_d   = !pkt_rx_eop;
            end else if (open_q) begin
                done_len = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
                len_d    = done_len;
                complete = pkt_rx_eop;
                open_d   = !pkt_rx_eop;
            end else begin
                fr_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= complete;
            case (state_q)
                IDLE: begin
                    if (pkt_rx_avail && !stall) begin
                        state_q <= READ;
                        ren_q   <= 1'b1;
                    end else begin
                        ren_q <= 1'b0;
                    end
                end
                READ: begin
                    ren_q <= !stall;
                end
                DONE: begin
                    state_q <= IDLE;
                    ren_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ren_q   <= 1'b0;
                end
            endcase
            // A completing word may also arrive in IDLE/DONE due to read latency.
            if (complete) begin
                state_q <= DONE;
                ren_q   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            open_q      <= 1'b0;
            len_q       <= '0;
            frame_len_q <= '0;
            frame_bad_q <= 1'b0;
        end else begin
            open_q <= open_d;
            len_q  <= len_d;
            if (complete) begin
                frame_len_q <= done_len;
                frame_bad_q <= pkt_rx_err;
            end
        end
    end

    xge_stat_counter #(.W(CNT_W)) u_frames_ok (
        .clk_i   (clk_156m25),
        .rst_ni  (reset_156m25_n),
        .clr_i   (clear_stats),
        .add_i   (CNT_W'(complete && !pkt_rx_err)),
        .count_o (frames_ok)
    );

    xge_stat_counter #(.W(CNT_W)) u_frames_err (
        .clk_i   (clk_156m25),
        .rst_ni  (reset_156m25_n),
        .clr_i   (clear_stats),
        .add_i   (CNT_W'(complete && pkt_rx_err)),
        .count_o (frames_err)
    );

    xge_stat_counter #(.W(CNT_W)) u_framing_err (
        .clk_i   (clk_156m25),
        .rst_ni  (reset_156m25_n),
        .clr_i   (clear_stats),
        .add_i   (CNT_W'(fr_err)),
        .count_o (framing_err)
    );

    xge_stat_counter #(.W(CNT_W)) u_bytes_total (
        .clk_i   (clk_156m25),
        .rst_ni  (reset_156m25_n),
        .clr_i   (clear_stats),
        .add_i   (complete ? CNT_W'(done_len) : '0),
        .count_o (bytes_total)
    );

    assign pkt_rx_ren = ren_q;
    assign frame_done = done_q;
    assign frame_len  = frame_len_q;
    assign frame_bad  = frame_bad_q;
    assign busy       = (state_q != IDLE);

endmodule
